agu_pipe_stage: RTL and testbench

Parametrised, registered address-generation stage between operand fetch and execute/memory. It computes up to NUM_CH effective addresses per instruction as base + (index << scale) + sign-extended displacement, and flags non-canonical results. An opaque decode payload passes through unchanged. A small in-order buffer with valid/ready handshake on both sides replaces the stall/wbStall qualification of the previous generation.

---
 rtl/agu_pkg.sv | 22 ++
 rtl/agu_addr_calc.sv | 51 +++++
 rtl/agu_pipe_stage.sv | 142 ++++++++++++++
 tb/tb_agu_pipe_stage.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/agu_pkg.sv
// Shared constants and types for the address-generation stage.
package agu_pkg;

  localparam int CH_SRC1   = 0;
  localparam int CH_SRC2   = 1;
  localparam int CH_DEST   = 2;

  // Highest implemented bit of a 48-bit canonical virtual address.
  localparam int CANON_MSB = 47;

  typedef enum logic [1:0] {
    SCALE_1 = 2'd0,
    SCALE_2 = 2'd1,
    SCALE_4 = 2'd2,
    SCALE_8 = 2'd3
  } scale_e;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/agu_addr_calc.sv
// Single-channel effective address: base + (index << scale) + sext(disp), plus canonical check.
// AGU_SEGMENT_BASE_EN adds an optional segment base term ahead of the check.
module agu_addr_calc
  import agu_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DISP_W = 32
) (
  input  logic              mem_access_i,
  input  logic [ADDR_W-1:0] base_i,
  input  logic [ADDR_W-1:0] index_i,
  input  logic              index_valid_i,
  input  logic [1:0]        scale_i,
  input  logic [DISP_W-1:0] disp_i,
`ifdef AGU_SEGMENT_BASE_EN
  input  logic [ADDR_W-1:0] seg_base_i,
  input  logic              seg_override_i,
`endif
  output logic [ADDR_W-1:0] addr_o,
  output logic              fault_o
);

  scale_e            scale;
  logic [ADDR_W-1:0] scaled_index;
  logic [ADDR_W-1:0] disp_ext;
  logic [ADDR_W-1:0] sum;

  assign scale        = scale_e'(scale_i);
  assign scaled_index = index_valid_i ? (index_i << scale) : '0;
  assign disp_ext     = ADDR_W'($signed(disp_i));

`ifdef AGU_SEGMENT_BASE_EN
  assign sum = base_i + scaled_index + disp_ext + (seg_override_i ? seg_base_i : '0);
`else
  assign sum = base_i + scaled_index + disp_ext;
`endif

  assign addr_o = mem_access_i ? sum : '0;

  // Canonical form only exists for 64-bit addresses; narrower builds never fault.
  generate
    if (ADDR_W == 64) begin : g_canon
      logic [ADDR_W-1:CANON_MSB] upper;
      assign upper   = sum[ADDR_W-1:CANON_MSB];
      assign fault_o = mem_access_i & ~((&upper) | ~(|upper));
    end else begin : g_no_canon
      assign fault_o = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/agu_pipe_stage.sv
// Registered AGU stage: computes NUM_CH effective addresses and buffers them in an in-order FIFO.
// Optional segment base adder enabled by defining AGU_SEGMENT_BASE_EN.
module agu_pipe_stage
  import agu_pkg::*;
#(
  parameter int ADDR_W    = 64,
  parameter int NUM_CH    = 3,
  parameter int DISP_W    = 32,
  parameter int PAYLOAD_W = 256,
  parameter int DEPTH     = 2
) (
  input  logic                     clk,
  input  logic                     resetN,
  input  logic                     flushIn,
  input  logic                     inValid,
  output logic                     inReady,
  input  logic [PAYLOAD_W-1:0]     inPayload,
  input  logic [NUM_CH-1:0]        inMemAccess,
  input  logic [NUM_CH*ADDR_W-1:0] inBase,
  input  logic [NUM_CH*ADDR_W-1:0] inIndex,
  input  logic [NUM_CH-1:0]        inIndexValid,
  input  logic [NUM_CH*2-1:0]      inScale,
  input  logic [NUM_CH*DISP_W-1:0] inDisp,
`ifdef AGU_SEGMENT_BASE_EN
  input  logic [ADDR_W-1:0]        segBaseIn,
  input  logic [NUM_CH-1:0]        inSegOverride,
`endif
  output logic                     outValid,
  input  logic                     outReady,
  output logic [PAYLOAD_W-1:0]     outPayload,
  output logic [NUM_CH-1:0]        outMemAccess,
  output logic [NUM_CH*ADDR_W-1:0] outAddr,
  output logic [NUM_CH-1:0]        outFault,
  output logic [31:0]              acceptedCount
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [PAYLOAD_W-1:0]     payload;
    logic [NUM_CH-1:0]        mem_access;
    logic [NUM_CH*ADDR_W-1:0] addr;
    logic [NUM_CH-1:0]        fault;
  } entry_t;

  entry_t                   mem_q [DEPTH];
  entry_t                   push_entry;
  entry_t                   head;
  logic [NUM_CH*ADDR_W-1:0] calc_addr;
  logic [NUM_CH-1:0]        calc_fault;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [31:0]      acc_cnt_q, acc_cnt_d;
  logic             rdy_en_q;
  logic             push, pop;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    agu_addr_calc #(
      .ADDR_W (ADDR_W),
      .DISP_W (DISP_W)
    ) u_calc (
      .mem_access_i   (inMemAccess[c]),
      .base_i         (inBase[c*ADDR_W +: ADDR_W]),
      .index_i        (inIndex[c*ADDR_W +: ADDR_W]),
      .index_valid_i  (inIndexValid[c]),
      .scale_i        (inScale[c*2 +: 2]),
      .disp_i         (inDisp[c*DISP_W +: DISP_W]),
`ifdef AGU_SEGMENT_BASE_EN
      .seg_base_i     (segBaseIn),
      .seg_override_i (inSegOverride[c]),
`endif
      .addr_o         (calc_addr[c*ADDR_W +: ADDR_W]),
      .fault_o        (calc_fault[c])
    );
  end

  assign push_entry = '{payload: inPayload, mem_access: inMemAccess,
                        addr: calc_addr, fault: calc_fault};

  // Ready depends on registered state only, so outReady never reaches inReady.
  assign inReady  = rdy_en_q & (count_q < CNT_W'(DEPTH));
  assign outValid = (count_q != '0);
  assign push     = inValid & inReady & ~flushIn;
  assign pop      = outValid & outReady & ~flushIn;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    acc_cnt_d = acc_cnt_q;
    if (flushIn) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d  = wr_ptr_q + PTR_W'(1);
        acc_cnt_d = sat_inc32(acc_cnt_q);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      acc_cnt_q <= '0;
      rdy_en_q  <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      acc_cnt_q <= acc_cnt_d;
      rdy_en_q  <= 1'b1;
    end
  end

  // NOTE: storage is not reset; the head is only exposed once written, and outputs are gated by outValid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_entry;
  end

  assign head          = mem_q[rd_ptr_q];
  assign outPayload    = outValid ? head.payload    : '0;
  assign outMemAccess  = outValid ? head.mem_access : '0;
  assign outAddr       = outValid ? head.addr       : '0;
  assign outFault      = outValid ? head.fault      : '0;
  assign acceptedCount = acc_cnt_q;

endmodule

// File: tb/tb_agu_pipe_stage.sv
// Scoreboard bench for agu_pipe_stage: reference model pushes expected entries, monitor pops and compares.
module tb_agu_pipe_stage;

  localparam int ADDR_W    = 64;
  localparam int NUM_CH    = 3;
  localparam int DISP_W    = 32;
  localparam int PAYLOAD_W = 256;
  localparam int DEPTH     = 2;

  logic                     clk = 1'b0;
  logic                     resetN = 1'b0;
  logic                     flushIn = 1'b0;
  logic                     inValid = 1'b0;
  logic                     inReady;
  logic [PAYLOAD_W-1:0]     inPayload = '0;
  logic [NUM_CH-1:0]        inMemAccess = '0;
  logic [NUM_CH*ADDR_W-1:0] inBase = '0;
  logic [NUM_CH*ADDR_W-1:0] inIndex = '0;
  logic [NUM_CH-1:0]        inIndexValid = '0;
  logic [NUM_CH*2-1:0]      inScale = '0;
  logic [NUM_CH*DISP_W-1:0] inDisp = '0;
`ifdef AGU_SEGMENT_BASE_EN
  logic [ADDR_W-1:0]        segBaseIn = '0;
  logic [NUM_CH-1:0]        inSegOverride = '0;
`endif
  logic                     outValid;
  logic                     outReady = 1'b0;
  logic [PAYLOAD_W-1:0]     outPayload;
  logic [NUM_CH-1:0]        outMemAccess;
  logic [NUM_CH*ADDR_W-1:0] outAddr;
  logic [NUM_CH-1:0]        outFault;
  logic [31:0]              acceptedCount;

  always #5 clk = ~clk;

  agu_pipe_stage #(
    .ADDR_W(ADDR_W), .NUM_CH(NUM_CH), .DISP_W(DISP_W),
    .PAYLOAD_W(PAYLOAD_W), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .resetN(resetN), .flushIn(flushIn),
    .inValid(inValid), .inReady(inReady), .inPayload(inPayload),
    .inMemAccess(inMemAccess), .inBase(inBase), .inIndex(inIndex),
    .inIndexValid(inIndexValid), .inScale(inScale), .inDisp(inDisp),
`ifdef AGU_SEGMENT_BASE_EN
    .segBaseIn(segBaseIn), .inSegOverride(inSegOverride),
`endif
    .outValid(outValid), .outReady(outReady), .outPayload(outPayload),
    .outMemAccess(outMemAccess), .outAddr(outAddr), .outFault(outFault),
    .acceptedCount(acceptedCount)
  );

  typedef struct {
    logic [PAYLOAD_W-1:0]     payload;
    logic [NUM_CH-1:0]        mem;
    logic [NUM_CH*ADDR_W-1:0] addr;
    logic [NUM_CH-1:0]        fault;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  logic [31:0] m_count = '0;
  bit          m_rdy = 1'b0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference: effective address from plain 64-bit arithmetic on the current inputs.
  function automatic exp_t model();
    exp_t              e;
    longint unsigned   mul [4] = '{1, 2, 4, 8};
    longint unsigned   a;
    longint unsigned   off;
    longint            d;
    longint            hi;
    e.payload = inPayload;
    e.mem     = inMemAccess;
    e.addr    = '0;
    e.fault   = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (inMemAccess[c]) begin
        off = inIndexValid[c] ? inIndex[c*ADDR_W +: ADDR_W] * mul[inScale[c*2 +: 2]] : 64'd0;
        d   = longint'($signed(inDisp[c*DISP_W +: DISP_W]));
        a   = inBase[c*ADDR_W +: ADDR_W] + off + longint'(d);
`ifdef AGU_SEGMENT_BASE_EN
        if (inSegOverride[c]) a = a + segBaseIn;
`endif
        hi  = longint'(a) >>> 47;
        e.addr[c*ADDR_W +: ADDR_W] = a;
        e.fault[c] = !(hi == 0 || hi == -1);
      end
    end
    return e;
  endfunction

  // Monitor: compares the presented head against the scoreboard front.
  always @(negedge clk) begin : mon
    bit popnow;
    check("out_valid", 256'(outValid), 256'(sb.size() != 0));
    check("in_ready", 256'(inReady), 256'(m_rdy && sb.size() < DEPTH));
    check("accepted_count", 256'(acceptedCount), 256'(m_count));
    if (outValid && sb.size() != 0) begin
      check("head_payload", 256'(outPayload), 256'(sb[0].payload));
      check("head_mem", 256'(outMemAccess), 256'(sb[0].mem));
      check("head_addr", 256'(outAddr), 256'(sb[0].addr));
      check("head_fault", 256'(outFault), 256'(sb[0].fault));
    end
    popnow = outValid && outReady && !flushIn && resetN && sb.size() != 0;
    if (popnow) begin
      @(posedge clk);
      #1;
      if (sb.size() != 0 && resetN) void'(sb.pop_front());
    end
  end

  task automatic cycle(input bit v, input bit fl, input bit ordy, output bit acc);
    exp_t e;
    inValid  = v;
    flushIn  = fl;
    outReady = ordy;
    @(negedge clk);
    acc = v && !fl && m_rdy && sb.size() < DEPTH;
    e   = model();
    @(posedge clk);
    #1;
    if (fl) sb.delete();
    else if (acc) sb.push_back(e);
    if (acc && m_count != 32'hFFFF_FFFF) m_count = m_count + 1;
  endtask

  task automatic do_reset();
    inValid = 1'b0; flushIn = 1'b0; outReady = 1'b0;
    resetN = 1'b0;
    sb.delete(); m_rdy = 1'b0; m_count = '0;
    repeat (2) @(negedge clk);
    @(posedge clk); #1 resetN = 1'b1;
    @(posedge clk); #1 m_rdy = 1'b1;
  endtask

  task automatic clear_inputs();
    inPayload = '0; inMemAccess = '0; inBase = '0; inIndex = '0;
    inIndexValid = '0; inScale = '0; inDisp = '0;
`ifdef AGU_SEGMENT_BASE_EN
    segBaseIn = '0; inSegOverride = '0;
`endif
  endtask

  task automatic set_ch(input int c, input bit m, input logic [63:0] b, input logic [63:0] idx,
                        input bit iv, input logic [1:0] sc, input logic [31:0] dp);
    inMemAccess[c] = m;
    inBase[c*ADDR_W +: ADDR_W] = b;
    inIndex[c*ADDR_W +: ADDR_W] = idx;
    inIndexValid[c] = iv;
    inScale[c*2 +: 2] = sc;
    inDisp[c*DISP_W +: DISP_W] = dp;
  endtask

  task automatic drain();
    bit acc;
    for (int i = 0; i < 8 && sb.size() != 0; i++) cycle(1'b0, 1'b0, 1'b1, acc);
    check("drain_timeout", 256'(sb.size()), 256'(0));
  endtask

  initial begin
    bit          acc;
    logic [31:0] cnt_before;
    logic [63:0] seg_exp;

    do_reset();

    // Scaled index plus negative displacement.
    clear_inputs();
    inPayload = 256'h1111;
    set_ch(0, 1'b1, 64'h1000, 64'h10, 1'b1, 2'd3, 32'hFFFF_FFF8);
    cycle(1'b1, 1'b0, 1'b0, acc);
    check("t1_valid_latency1", 256'(outValid), 256'(1));
    check("t1_addr0", 256'(outAddr[63:0]), 256'(64'h1078));
    check("t1_fault0", 256'(outFault[0]), 256'(0));
    drain();

    // Non-canonical crossing and a channel without a memory operand.
    clear_inputs();
    inPayload = 256'h2222;
    set_ch(1, 1'b0, 64'hDEAD_BEEF, 64'h5, 1'b1, 2'd1, 32'h7);
    set_ch(2, 1'b1, 64'h0000_7FFF_FFFF_FFF0, 64'h0, 1'b0, 2'd0, 32'h20);
    cycle(1'b1, 1'b0, 1'b0, acc);
    check("t2_addr2", 256'(outAddr[191:128]), 256'(64'h0000_8000_0000_0010));
    check("t2_fault2", 256'(outFault[2]), 256'(1));
    check("t2_addr1", 256'(outAddr[127:64]), 256'(0));
    check("t2_fault1", 256'(outFault[1]), 256'(0));
    drain();

    // Full buffer back-pressure: A, B accepted, C stalls until a slot frees.
    do_reset();
    clear_inputs();
    inPayload = 256'hA; cycle(1'b1, 1'b0, 1'b0, acc);
    inPayload = 256'hB; cycle(1'b1, 1'b0, 1'b0, acc);
    inPayload = 256'hC; cycle(1'b1, 1'b0, 1'b0, acc);
    check("t3_c_stalled", 256'(acc), 256'(0));
    check("t3_in_ready_full", 256'(inReady), 256'(0));
    acc = 1'b0;
    for (int i = 0; i < 4 && !acc; i++) cycle(1'b1, 1'b0, 1'b1, acc);
    check("t3_c_accepted", 256'(acc), 256'(1));
    inValid = 1'b0;
    drain();
    check("t3_count3", 256'(acceptedCount), 256'(3));

    // Flush discards buffered and same-cycle input.
    clear_inputs();
    inPayload = 256'hD1; cycle(1'b1, 1'b0, 1'b0, acc);
    inPayload = 256'hD2; cycle(1'b1, 1'b0, 1'b0, acc);
    cnt_before = acceptedCount;
    inPayload = 256'hD3; cycle(1'b1, 1'b1, 1'b0, acc);
    flushIn = 1'b0; inValid = 1'b0;
    check("t4_flush_valid", 256'(outValid), 256'(0));
    check("t4_flush_ready", 256'(inReady), 256'(1));
    check("t4_flush_count", 256'(acceptedCount), 256'(cnt_before));

    // Asynchronous reset while holding a valid head.
    inPayload = 256'hE1; cycle(1'b1, 1'b0, 1'b0, acc);
    inValid = 1'b0;
    #2 resetN = 1'b0;
    #1 check("t5_async_reset_valid", 256'(outValid), 256'(0));
    do_reset();
    inPayload = 256'hE2;
    set_ch(0, 1'b1, 64'h40, 64'h0, 1'b0, 2'd0, 32'h4);
    cycle(1'b1, 1'b0, 1'b0, acc);
    check("t5_post_reset_latency", 256'(outValid), 256'(1));
    drain();

    // Segment base term on an overridden channel.
    clear_inputs();
    inPayload = 256'hF0;
    set_ch(0, 1'b1, 64'h10, 64'h0, 1'b0, 2'd0, 32'h0);
`ifdef AGU_SEGMENT_BASE_EN
    segBaseIn = 64'h10000; inSegOverride = 3'b001;
    seg_exp = 64'h10010;
`else
    seg_exp = 64'h10;
`endif
    cycle(1'b1, 1'b0, 1'b0, acc);
    check("t6_segment", 256'(outAddr[63:0]), 256'(seg_exp));
    drain();

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      for (int w = 0; w < PAYLOAD_W / 32; w++) inPayload[w*32 +: 32] = $urandom;
      for (int c = 0; c < NUM_CH; c++)
        set_ch(c, 1'($urandom_range(0, 1)),
               ($urandom_range(0, 1) != 0) ? {$urandom, $urandom} : {32'h0000_7FFF, $urandom},
               ($urandom_range(0, 1) != 0) ? {$urandom, $urandom} : {48'h0, 16'($urandom)},
               1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom);
`ifdef AGU_SEGMENT_BASE_EN
      segBaseIn = {$urandom, $urandom};
      inSegOverride = 3'($urandom_range(0, 7));
`endif
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, $urandom_range(0, 2) != 0, acc);
    end
    inValid = 1'b0; flushIn = 1'b0;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
